packet_rx_mb: RTL

PACKET_RX_MB -- requirements
Module: packet_rx_mb

---
 rtl/packet_rx_mb_if.sv | 27 ++
 rtl/packet_rx_mb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/packet_rx_mb_if.sv
// Receive-side bus bundle: byte stream in, buffer write port and
// buffer-status handshake out. The slave view belongs to the receiver.
interface packet_rx_mb_if #(
  parameter int PAYLOAD_AW = 6,
  parameter int BUF_AW     = 1
);
  logic [7:0]                   data;
  logic [1:0]                   ctl;
  logic [47:0]                  mac_addr;
  logic                         eth_rx_read;
  logic [BUF_AW+PAYLOAD_AW-1:0] eth_rx_addr;
  logic [7:0]                   eth_rx_wdata;
  logic                         eth_rx_we;
  logic                         eth_rx_ready;
  logic [BUF_AW-1:0]            eth_rx_rbuf;
  logic [15:0]                  drop_count;

  modport slave (
    input  data, ctl, mac_addr, eth_rx_read,
    output eth_rx_addr, eth_rx_wdata, eth_rx_we, eth_rx_ready, eth_rx_rbuf, drop_count
  );

  modport master (
    output data, ctl, mac_addr, eth_rx_read,
    input  eth_rx_addr, eth_rx_wdata, eth_rx_we, eth_rx_ready, eth_rx_rbuf, drop_count
  );
endinterface

// File: rtl/packet_rx_mb.sv
// Frame receiver: filters on destination address, writes a fixed-size payload
// window into one of NBUF ring buffers and hands full buffers to a reader.
module packet_rx_mb #(
  parameter int PAYLOAD_AW     = 6,
  parameter int PAYLOAD_OFFSET = 14,
  parameter int BUF_AW         = 1,
  parameter int ACCEPT_BCAST   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  packet_rx_mb_if.slave  bus
);
  localparam int NBUF = 1 << BUF_AW;

  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, PREAMBLE, HEADER, PAYLOAD, TAIL, DISCARD
  } state_t;

  state_t                       r_state, w_state_next;
  logic [7:0]                   r_cnt, w_cnt_next;
  logic                         r_ucast_mis, w_ucast_mis_next;
  logic                         r_bcast_mis, w_bcast_mis_next;
  logic [PAYLOAD_AW-1:0]        r_widx, w_widx_next;
  logic [BUF_AW-1:0]            r_wptr, r_rptr;
  logic [BUF_AW:0]              r_full;
  logic                         r_we;
  logic [BUF_AW+PAYLOAD_AW-1:0] r_addr;
  logic [7:0]                   r_wdata;
  logic [15:0]                  r_drop;

  logic       w_valid, w_idle, w_err;
  logic       w_write, w_commit, w_drop, w_rd;
  logic       w_in_dst, w_last_hdr, w_buf_free, w_match;
  logic [7:0] w_mac_byte;
  logic [7:0] w_mac_bytes [0:7];

  assign w_valid = (bus.ctl == 2'b11);
  assign w_idle  = (bus.ctl == 2'b00);
  assign w_err   = bus.ctl[1] ^ bus.ctl[0];

  // destination byte 0 is the most significant byte of the station address
  for (genvar gi = 0; gi < 8; gi++) begin : g_mac
    if (gi < 6) begin : g_byte
      assign w_mac_bytes[gi] = bus.mac_addr[47-8*gi -: 8];
    end else begin : g_pad
      assign w_mac_bytes[gi] = 8'h00;
    end
  end

  assign w_in_dst   = (r_cnt < 8'd6);
  assign w_mac_byte = w_mac_bytes[r_cnt[2:0]];
  assign w_last_hdr = (r_cnt == 8'(PAYLOAD_OFFSET - 1));
  assign w_buf_free = (r_full < (BUF_AW+1)'(NBUF));
  assign w_rd       = bus.eth_rx_read && (r_full != '0);

  // the match decision includes the byte being accepted right now, so the
  // shortest legal offset (6) still sees the last destination byte
  assign w_ucast_mis_next = r_ucast_mis | (w_in_dst && (bus.data != w_mac_byte));
  assign w_bcast_mis_next = r_bcast_mis | (w_in_dst && (bus.data != 8'hff));
  assign w_match = !w_ucast_mis_next || ((ACCEPT_BCAST != 0) && !w_bcast_mis_next);

  // next-state, counters and per-cycle strobes
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_widx_next  = r_widx;
    w_write      = 1'b0;
    w_commit     = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      WAIT_IDLE: if (w_idle) w_state_next = IDLE;
      IDLE: begin
        if (w_valid) w_state_next = (bus.data == 8'h55) ? PREAMBLE : DISCARD;
      end
      PREAMBLE: begin
        if (w_err)       w_state_next = DISCARD;
        else if (w_idle) w_state_next = IDLE;
        else if (bus.data == 8'hd5) begin
          w_state_next = HEADER;
          w_cnt_next   = 8'd0;
        end else if (bus.data != 8'h55) w_state_next = DISCARD;
      end
      HEADER: begin
        if (w_err)       w_state_next = DISCARD;
        else if (w_idle) w_state_next = IDLE;
        else begin
          w_cnt_next = r_cnt + 8'd1;
          if (w_last_hdr) begin
            if (!w_match) w_state_next = DISCARD;
            else if (!w_buf_free) begin
              w_state_next = DISCARD;
              w_drop       = 1'b1;
            end else begin
              w_state_next = PAYLOAD;
              w_widx_next  = '0;
            end
          end
        end
      end
      PAYLOAD: begin
        if (w_err)       w_state_next = DISCARD;
        else if (w_idle) w_state_next = IDLE;
        else begin
          w_write     = 1'b1;
          w_widx_next = r_widx + 1'b1;
          if (&r_widx) w_state_next = TAIL;
        end
      end
      TAIL: begin
        if (w_err) w_state_next = DISCARD;
        else if (w_idle) begin
          w_commit     = 1'b1;
          w_state_next = IDLE;
        end
      end
      DISCARD: if (w_idle) w_state_next = IDLE;
      default: w_state_next = WAIT_IDLE;
    endcase
  end

  // FSM state and header tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_IDLE;
      r_cnt       <= '0;
      r_ucast_mis <= 1'b0;
      r_bcast_mis <= 1'b0;
      r_widx      <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_widx  <= w_widx_next;
      if (r_state == PREAMBLE) begin
        r_ucast_mis <= 1'b0;
        r_bcast_mis <= 1'b0;
      end else if (r_state == HEADER && w_valid) begin
        r_ucast_mis <= w_ucast_mis_next;
        r_bcast_mis <= w_bcast_mis_next;
      end
    end
  end

  // registered write port: one stage between sampled byte and strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr  <= {r_wptr, r_widx};
        r_wdata <= bus.data;
      end
    end
  end

  // buffer ring bookkeeping and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= '0;
      r_drop <= '0;
    end else begin
      if (w_commit) r_wptr <= r_wptr + 1'b1;
      if (w_rd)     r_rptr <= r_rptr + 1'b1;
      case ({w_commit, w_rd})
        2'b10:   r_full <= r_full + 1'b1;
        2'b01:   r_full <= r_full - 1'b1;
        default: r_full <= r_full;
      endcase
      if (w_drop && (r_drop != 16'hffff)) r_drop <= r_drop + 16'd1;
    end
  end

  assign bus.eth_rx_we    = r_we;
  assign bus.eth_rx_addr  = r_addr;
  assign bus.eth_rx_wdata = r_wdata;
  assign bus.eth_rx_ready = (r_full != '0);
  assign bus.eth_rx_rbuf  = r_rptr;
  assign bus.drop_count   = r_drop;
endmodule
